// File: rtl/mem_pkg.sv
// mem_pkg: shared types and constants for the MEM stage
package mem_pkg;
   typedef enum logic {LIBRE = 1'b0, ESPERA = 1'b1} estado_t;
   localparam int ANCHO_DEF = 32;
   localparam int CONT_W    = 8;
endpackage

// File: rtl/mem_etapa_buffer3.sv
// buffer3: EX/MEM pipeline register, holds its contents while hold_i is high
module buffer3
   import mem_pkg::*;
#(
   parameter int ANCHO = ANCHO_DEF
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             hold_i,
   input  logic [ANCHO-1:0] resultado_i,
   input  logic [ANCHO-1:0] dato_i,
   input  logic [4:0]       rd_i,
   input  logic             reg_escribir_i,
   input  logic             mem_a_reg_i,
   input  logic             mem_escribir_i,
   input  logic             mem_leer_i,
   output logic [ANCHO-1:0] resultado_o,
   output logic [ANCHO-1:0] dato_o,
   output logic [4:0]       rd_o,
   output logic             reg_escribir_o,
   output logic             mem_a_reg_o,
   output logic             mem_escribir_o,
   output logic             mem_leer_o
);
   logic [ANCHO-1:0] resultado_q, dato_q;
   logic [4:0]       rd_q;
   logic             reg_escribir_q, mem_a_reg_q, mem_escribir_q, mem_leer_q;
   // Capture the EX outputs unless the stage is stalled
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         resultado_q    <= '0;
         dato_q         <= '0;
         rd_q           <= '0;
         reg_escribir_q <= 1'b0;
         mem_a_reg_q    <= 1'b0;
         mem_escribir_q <= 1'b0;
         mem_leer_q     <= 1'b0;
      end else if (!hold_i) begin
         resultado_q    <= resultado_i;
         dato_q         <= dato_i;
         rd_q           <= rd_i;
         reg_escribir_q <= reg_escribir_i;
         mem_a_reg_q    <= mem_a_reg_i;
         mem_escribir_q <= mem_escribir_i;
         mem_leer_q     <= mem_leer_i;
      end
   end
   assign resultado_o    = resultado_q;
   assign dato_o         = dato_q;
   assign rd_o           = rd_q;
   assign reg_escribir_o = reg_escribir_q;
   assign mem_a_reg_o    = mem_a_reg_q;
   assign mem_escribir_o = mem_escribir_q;
   assign mem_leer_o     = mem_leer_q;
endmodule

// File: rtl/mem_etapa.sv
// mem_etapa: MEM pipeline stage with req/ack data-memory access and MEM/WB register
module mem_etapa
   import mem_pkg::*;
#(
   parameter int ANCHO         = ANCHO_DEF,
   parameter int LIMITE_ESPERA = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [ANCHO-1:0] resultado_alu_EX,
   input  logic [ANCHO-1:0] dr2_forward_EX,
   input  logic [4:0]       registro_destino_EX,
   input  logic             reg_escribir_EX,
   input  logic             mem_a_reg_EX,
   input  logic             mem_escribir_EX,
   input  logic             mem_leer_EX,
   output logic             stall_MEM,
   output logic             dm_req,
   output logic             dm_we,
   output logic [ANCHO-1:0] dm_addr,
   output logic [ANCHO-1:0] dm_wdata,
   input  logic             dm_ack,
   input  logic [ANCHO-1:0] dm_rdata,
   output logic [ANCHO-1:0] dato_leido_WB,
   output logic [ANCHO-1:0] resultado_alu_WB,
   output logic [4:0]       registro_destino_WB,
   output logic             reg_escribir_WB,
   output logic             mem_a_reg_WB,
   output logic             valido_WB,
   output logic             error_alineacion,
   output logic             error_tiempo
);
   logic [ANCHO-1:0]  res_q, dato_q, dato_wb_q, res_wb_q;
   logic [4:0]        rd_q, rd_wb_q;
   logic              re_q, mr_q, mw_q, ml_q, re_wb_q, mr_wb_q;
   logic              valido_q, err_al_q, err_t_q;
   estado_t           estado_q, estado_d;
   logic [CONT_W-1:0] cont_q, cont_d;
   logic              hecho_q, hecho_d;
   logic              es_mem, desalineado, pide, acepta, agota, fin, escribe_wb;

   buffer3 #(.ANCHO(ANCHO)) u_ex_mem (
      .clk_i(clk), .rst_i(reset), .hold_i(stall_MEM),
      .resultado_i(resultado_alu_EX), .dato_i(dr2_forward_EX), .rd_i(registro_destino_EX),
      .reg_escribir_i(reg_escribir_EX), .mem_a_reg_i(mem_a_reg_EX),
      .mem_escribir_i(mem_escribir_EX), .mem_leer_i(mem_leer_EX),
      .resultado_o(res_q), .dato_o(dato_q), .rd_o(rd_q),
      .reg_escribir_o(re_q), .mem_a_reg_o(mr_q),
      .mem_escribir_o(mw_q), .mem_leer_o(ml_q)
   );

   // Request decode: hecho_q marks a latched op already finished so it is not reissued
   always_comb begin
      es_mem      = mw_q | ml_q;
      desalineado = es_mem && (res_q[1:0] != 2'b00);
      pide        = (estado_q == ESPERA) || (es_mem && !desalineado && !hecho_q);
      acepta      = pide && dm_ack;
      agota       = pide && !dm_ack && ((cont_q + 1'b1) == CONT_W'(LIMITE_ESPERA));
      fin         = acepta || agota;
      escribe_wb  = pide ? fin : !hecho_q;
      estado_d    = (pide && !fin) ? ESPERA : LIBRE;
      cont_d      = (pide && !fin) ? cont_q + 1'b1 : '0;
      hecho_d     = fin;
   end

   assign stall_MEM = pide;
   assign dm_req    = pide;
   assign dm_we     = mw_q;
   assign dm_addr   = res_q;
   assign dm_wdata  = dato_q;

   // Access FSM, wait counter and one-cycle status pulses
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         estado_q <= LIBRE;
         cont_q   <= '0;
         hecho_q  <= 1'b0;
         valido_q <= 1'b0;
         err_al_q <= 1'b0;
         err_t_q  <= 1'b0;
      end else begin
         estado_q <= estado_d;
         cont_q   <= cont_d;
         hecho_q  <= hecho_d;
         valido_q <= escribe_wb;
         err_al_q <= escribe_wb && desalineado;
         err_t_q  <= agota;
      end
   end

   // MEM/WB register; dropped or aborted accesses never write a register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         dato_wb_q <= '0;
         res_wb_q  <= '0;
         rd_wb_q   <= '0;
         re_wb_q   <= 1'b0;
         mr_wb_q   <= 1'b0;
      end else if (escribe_wb) begin
         res_wb_q <= res_q;
         rd_wb_q  <= rd_q;
         mr_wb_q  <= mr_q;
         re_wb_q  <= re_q && !desalineado && !agota;
         if (acepta && !mw_q) dato_wb_q <= dm_rdata;
      end
   end

   assign dato_leido_WB       = dato_wb_q;
   assign resultado_alu_WB    = res_wb_q;
   assign registro_destino_WB = rd_wb_q;
   assign reg_escribir_WB     = re_wb_q;
   assign mem_a_reg_WB        = mr_wb_q;
   assign valido_WB           = valido_q;
   assign error_alineacion    = err_al_q;
   assign error_tiempo        = err_t_q;
endmodule

// File: tb/tb_mem_etapa.sv
// tb_mem_etapa: scoreboard bench for the MEM stage with a latency-programmable memory
module tb_mem_etapa;
   logic        clk = 1'b0, reset;
   logic [31:0] resultado_alu_EX, dr2_forward_EX, dm_addr, dm_wdata, dm_rdata;
   logic [31:0] dato_leido_WB, resultado_alu_WB;
   logic [4:0]  registro_destino_EX, registro_destino_WB;
   logic        reg_escribir_EX, mem_a_reg_EX, mem_escribir_EX, mem_leer_EX;
   logic        stall_MEM, dm_req, dm_we, dm_ack;
   logic        reg_escribir_WB, mem_a_reg_WB, valido_WB, error_alineacion, error_tiempo;

   typedef struct {
      logic [31:0] res, dato, rdata;
      logic [4:0]  rd;
      logic        re, mr, mw, ml;
      int          lat;
   } instr_t;
   typedef struct {
      logic [31:0] res, wdata, dato;
      logic [4:0]  rd;
      logic        re, mr, we, eal, et;
      int          len;
   } esp_t;

   esp_t        cola[$];
   esp_t        mon_e;
   instr_t      tabla[10];
   instr_t      alu_post;
   int          n_chk = 0, n_fail = 0;
   int          cur_lat = 0, cyc = 0, scyc = 0;
   logic [31:0] cur_rdata = '0, dato_modelo = '0;
   bit          activo = 1'b0;

   mem_etapa #(.ANCHO(32), .LIMITE_ESPERA(16)) dut (
      .clk(clk), .reset(reset),
      .resultado_alu_EX(resultado_alu_EX), .dr2_forward_EX(dr2_forward_EX),
      .registro_destino_EX(registro_destino_EX), .reg_escribir_EX(reg_escribir_EX),
      .mem_a_reg_EX(mem_a_reg_EX), .mem_escribir_EX(mem_escribir_EX), .mem_leer_EX(mem_leer_EX),
      .stall_MEM(stall_MEM), .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr),
      .dm_wdata(dm_wdata), .dm_ack(dm_ack), .dm_rdata(dm_rdata),
      .dato_leido_WB(dato_leido_WB), .resultado_alu_WB(resultado_alu_WB),
      .registro_destino_WB(registro_destino_WB), .reg_escribir_WB(reg_escribir_WB),
      .mem_a_reg_WB(mem_a_reg_WB), .valido_WB(valido_WB),
      .error_alineacion(error_alineacion), .error_tiempo(error_tiempo)
   );

   always #5 clk = ~clk;

   task automatic chequear(input string tag, input logic [31:0] obs, input logic [31:0] esp);
      n_chk++;
      if (obs !== esp) begin
         n_fail++;
         $display("FAIL %s: obtenido=%h esperado=%h", tag, obs, esp);
      end
   endtask

   function automatic instr_t mk(input logic [31:0] res, input logic [31:0] dato, input logic [4:0] rd,
                                 input logic re, input logic mr, input logic mw, input logic ml,
                                 input int lat, input logic [31:0] rdata);
      instr_t i;
      i.res = res; i.dato = dato; i.rd = rd; i.re = re; i.mr = mr;
      i.mw = mw; i.ml = ml; i.lat = lat; i.rdata = rdata;
      return i;
   endfunction

   task automatic empujar(input instr_t i);
      esp_t e;
      logic mem, mis;
      mem = i.mw | i.ml;
      mis = mem && (i.res[1:0] != 2'b00);
      e.res = i.res; e.rd = i.rd; e.mr = i.mr; e.we = i.mw; e.wdata = i.dato;
      e.re = i.re; e.eal = mis; e.et = 1'b0; e.len = 0;
      if (mis) e.re = 1'b0;
      else if (mem) begin
         if (i.lat == 0 || i.lat > 16) begin
            e.et = 1'b1; e.re = 1'b0; e.len = 16;
         end else begin
            e.len = i.lat;
            if (!i.mw) dato_modelo = i.rdata;
         end
      end
      e.dato = dato_modelo;
      cola.push_back(e);
   endtask

   task automatic conducir(input instr_t i);
      int n;
      resultado_alu_EX = i.res; dr2_forward_EX = i.dato; registro_destino_EX = i.rd;
      reg_escribir_EX = i.re; mem_a_reg_EX = i.mr; mem_escribir_EX = i.mw; mem_leer_EX = i.ml;
      empujar(i);
      for (n = 0; n < 100; n++) begin
         @(negedge clk);
         if (!stall_MEM) break;
      end
      if (n == 100) chequear("captura_bloqueada", {31'd0, stall_MEM}, 32'd0);
      @(posedge clk);
      cur_lat = i.lat;
      cur_rdata = i.rdata;
      #1;
   endtask

   task automatic entradas_nulas();
      resultado_alu_EX = '0; dr2_forward_EX = '0; registro_destino_EX = '0;
      reg_escribir_EX = 1'b0; mem_a_reg_EX = 1'b0; mem_escribir_EX = 1'b0; mem_leer_EX = 1'b0;
   endtask

   // memory model plus scoreboard pop; acks while no request are deliberately injected
   always @(negedge clk) begin
      if (reset) begin
         cyc = 0; scyc = 0;
         dm_ack = 1'b1; dm_rdata = 32'hBAD0BAD0;
      end else begin
         if (activo && valido_WB) begin
            if (cola.size() == 0) chequear("valido_sin_esperado", {31'd0, valido_WB}, 32'd0);
            else begin
               mon_e = cola.pop_front();
               chequear("resultado_wb", resultado_alu_WB, mon_e.res);
               chequear("rd_wb", {27'd0, registro_destino_WB}, {27'd0, mon_e.rd});
               chequear("reg_escribir_wb", {31'd0, reg_escribir_WB}, {31'd0, mon_e.re});
               chequear("mem_a_reg_wb", {31'd0, mem_a_reg_WB}, {31'd0, mon_e.mr});
               chequear("dato_leido_wb", dato_leido_WB, mon_e.dato);
               chequear("error_alineacion", {31'd0, error_alineacion}, {31'd0, mon_e.eal});
               chequear("error_tiempo", {31'd0, error_tiempo}, {31'd0, mon_e.et});
               chequear("ciclos_req", cyc, mon_e.len);
               chequear("ciclos_stall", scyc, mon_e.len);
            end
            cyc = 0; scyc = 0;
         end
         if (activo && !valido_WB) begin
            chequear("pulso_alin_sin_valido", {31'd0, error_alineacion}, 32'd0);
            chequear("pulso_tiempo_sin_valido", {31'd0, error_tiempo}, 32'd0);
         end
         if (stall_MEM) scyc++;
         if (dm_req) begin
            cyc++;
            if (cola.size() > 0) begin
               chequear("dm_addr", dm_addr, cola[0].res);
               chequear("dm_we", {31'd0, dm_we}, {31'd0, cola[0].we});
               chequear("dm_wdata", dm_wdata, cola[0].wdata);
            end
            dm_ack = (cyc == cur_lat);
            dm_rdata = dm_ack ? cur_rdata : 32'hBAD0BAD0;
         end else begin
            dm_ack = 1'b1;
            dm_rdata = 32'hBAD0BAD0;
         end
      end
   end

   initial begin
      int n;
      reset = 1'b1;
      dm_ack = 1'b0; dm_rdata = '0;
      entradas_nulas();
      tabla[0] = mk(32'h40,  32'h0,    5'd5,  1, 0, 0, 0, 0,  32'h0);
      tabla[1] = mk(32'h100, 32'h0,    5'd8,  1, 1, 0, 1, 3,  32'hDEADBEEF);
      tabla[2] = mk(32'h104, 32'h1234, 5'd0,  0, 0, 1, 0, 1,  32'h0);
      tabla[3] = mk(32'h102, 32'h0,    5'd9,  1, 1, 0, 1, 1,  32'h11111111);
      tabla[4] = mk(32'h200, 32'h0,    5'd10, 1, 1, 0, 1, 0,  32'h0);
      tabla[5] = mk(32'h7,   32'h0,    5'd31, 1, 0, 0, 0, 0,  32'h0);
      tabla[6] = mk(32'h108, 32'hCAFE, 5'd12, 1, 1, 1, 1, 2,  32'hAAAA);
      tabla[7] = mk(32'h10C, 32'h0,    5'd13, 1, 1, 0, 1, 1,  32'h55);
      tabla[8] = mk(32'h110, 32'h0,    5'd14, 1, 1, 0, 1, 16, 32'h77);
      tabla[9] = mk(32'h3,   32'h0,    5'd2,  1, 0, 0, 0, 0,  32'h0);
      alu_post = mk(32'h99,  32'h0,    5'd3,  1, 0, 0, 0, 0,  32'h0);
      repeat (2) @(posedge clk);
      #1;
      chequear("reset_dm_req", {31'd0, dm_req}, 32'd0);
      chequear("reset_stall", {31'd0, stall_MEM}, 32'd0);
      chequear("reset_valido", {31'd0, valido_WB}, 32'd0);
      chequear("reset_resultado", resultado_alu_WB, 32'd0);
      empujar(mk(0, 0, 0, 0, 0, 0, 0, 0, 0));
      activo = 1'b1;
      #1 reset = 1'b0;
      #1;
      chequear("post_reset_dm_req", {31'd0, dm_req}, 32'd0);
      chequear("post_reset_valido", {31'd0, valido_WB}, 32'd0);
      foreach (tabla[k]) conducir(tabla[k]);
      conducir(mk(32'h300, 32'h0, 5'd4, 1, 1, 0, 1, 0, 32'h0));
      repeat (3) @(posedge clk);
      #2 reset = 1'b1;
      #1;
      chequear("reset_espera_dm_req", {31'd0, dm_req}, 32'd0);
      chequear("reset_espera_stall", {31'd0, stall_MEM}, 32'd0);
      chequear("reset_espera_valido", {31'd0, valido_WB}, 32'd0);
      chequear("reset_espera_dato", dato_leido_WB, 32'd0);
      chequear("reset_espera_resultado", resultado_alu_WB, 32'd0);
      chequear("reset_espera_rd", {27'd0, registro_destino_WB}, 32'd0);
      chequear("reset_espera_re", {31'd0, reg_escribir_WB}, 32'd0);
      cola.delete();
      dato_modelo = '0;
      cur_lat = 0;
      @(posedge clk);
      #2 reset = 1'b0;
      #1;
      chequear("tras_reset_dm_req", {31'd0, dm_req}, 32'd0);
      chequear("tras_reset_stall", {31'd0, stall_MEM}, 32'd0);
      empujar(mk(0, 0, 0, 0, 0, 0, 0, 0, 0));
      conducir(alu_post);
      entradas_nulas();
      for (n = 0; n < 200; n++) begin
         @(posedge clk);
         if (cola.size() == 0) break;
      end
      activo = 1'b0;
      chequear("cola_pendiente", cola.size(), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/mem_etapa.md
Name: mem_etapa

Overview:
MEM pipeline stage of the MIPS core, and the consumer of the EX/MEM interface that the execute stage drives. It holds the EX/MEM pipeline register and runs data-memory loads and stores over a req/ack handshake. When memory is slow it asserts a stall back toward IF/ID/EX. It delivers results, load data and control signals to the MEM/WB (writeback) interface.

Parameters:
ANCHO, 32, datapath and memory data/address width
LIMITE_ESPERA, 16, maximum ESPERA cycles before a memory access is aborted (range 1..255)

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-high reset
resultado_alu_EX  input  ANCHO  ALU result; the memory address for loads and stores
dr2_forward_EX  input  ANCHO  store data
registro_destino_EX  input  5  destination register
reg_escribir_EX  input  1  register-write enable
mem_a_reg_EX  input  1  writeback selects memory data
mem_escribir_EX  input  1  store
mem_leer_EX  input  1  load
stall_MEM  output  1  hold upstream stages and EX outputs
dm_req  output  1  memory request
dm_we  output  1  1 = write, 0 = read
dm_addr  output  ANCHO  byte address
dm_wdata  output  ANCHO  write data
dm_ack  input  1  memory completes the request at this edge
dm_rdata  input  ANCHO  read data, valid when dm_ack=1
dato_leido_WB  output  ANCHO  registered load data
resultado_alu_WB  output  ANCHO  registered ALU result
registro_destino_WB  output  5  registered destination register
reg_escribir_WB  output  1  registered write enable (qualified)
mem_a_reg_WB  output  1  registered select
valido_WB  output  1  MEM/WB slot updated this cycle
error_alineacion  output  1  one-cycle pulse: misaligned access dropped
error_tiempo  output  1  one-cycle pulse: access aborted on timeout

Behaviour:
- Reset (async): all registers are 0, FSM is in LIBRE, the wait counter is 0. Every output is 0 while reset is high and immediately after release; dm_req drops in the same instant reset rises.
- EX/MEM register: loads every EX input on a rising edge when stall_MEM=0, and holds when stall_MEM=1. A bubble is an instruction with all control bits 0.
- dm_addr, dm_wdata and dm_we are driven from the EX/MEM register and stay stable for the whole of ESPERA.
- dm_we=1 when mem_escribir is set. If both mem_escribir and mem_leer are set, the write takes priority and the read is ignored.
- A latched access is misaligned when addr[1:0] != 0.
- FSM states: LIBRE and ESPERA.
- LIBRE, latched instruction is not a memory op:
  - at the next edge, MEM/WB loads resultado, registro_destino, reg_escribir and mem_a_reg, and dato_leido keeps its old value;
  - valido_WB=1 for that cycle; latency is 1 cycle.
- LIBRE, latched memory op with misaligned address:
  - no request is issued;
  - at the next edge, MEM/WB loads the op as a non-memory op with reg_escribir_WB forced to 0;
  - error_alineacion=1 for one cycle.
- LIBRE, latched memory op with aligned address: the state goes combinationally to ESPERA behaviour. stall_MEM=1 and dm_req=1 in this same cycle.
- ESPERA:
  - dm_req=1 and stall_MEM=1, and the counter increments each cycle.
  - If dm_ack=1 at an edge: MEM/WB loads, with dato_leido_WB=dm_rdata for a read; valido_WB=1; the FSM returns to LIBRE; the counter clears.
  - If the counter reaches LIMITE_ESPERA without dm_ack: the access is aborted, dm_req drops, and MEM/WB loads with reg_escribir_WB=0. error_tiempo=1 for one cycle, valido_WB=1, and the FSM returns to LIBRE.
- stall_MEM = (state==ESPERA) or (LIBRE and latched aligned memory op not yet acked).
- An ack in the first cycle gives a memory op 1 cycle of stall. The EX/MEM register captures the next instruction on the ack edge + 1.
- valido_WB=0 in every cycle in which MEM/WB is not written, which includes stall cycles (bubbles to WB).
- dm_ack while dm_req=0 is ignored.
- A store completes on ack with no register write unless reg_escribir_EX was set.

Decomposition:
Shared package mem_pkg holds:
- the state encoding, LIBRE=1'b0 and ESPERA=1'b1;
- ANCHO_DEF=32;
- the width of the 8-bit wait counter.

One natural sub-module is buffer3, the EX/MEM register with a hold enable, instantiated by mem_etapa.

Test Plan:
- ALU op: resultado=0x0000_0040, rd=5, reg_escribir=1 -> next cycle resultado_alu_WB=0x40, registro_destino_WB=5, valido_WB=1, stall_MEM=0.
- Load from 0x100 with ack in the 3rd ESPERA cycle and dm_rdata=0xDEADBEEF -> dm_req high for 3 cycles, stall_MEM high for 3 cycles, then dato_leido_WB=0xDEADBEEF and mem_a_reg_WB=1.
- Store to 0x104 with data 0x1234 and ack after 1 cycle -> dm_we=1, dm_addr=0x104, dm_wdata=0x1234, reg_escribir_WB=0.
- Load from 0x102 -> dm_req stays 0, error_alineacion pulses, reg_escribir_WB=0, no stall.
- Load with no ack -> error_tiempo pulses after 16 ESPERA cycles, dm_req drops, reg_escribir_WB=0, stall_MEM releases.
- Reset asserted mid-ESPERA -> dm_req, stall_MEM and all WB outputs are 0 immediately; after release, an ALU op completes normally.
